// File: rtl/axi_lite_read_slave_if.sv
// AXI4-Lite read-channel bundle (AR + R) shared between the interconnect master
// and the register-bank read responder.
interface axi_lite_read_slave_if #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
);
    logic                  ARVALID;
    logic                  ARREADY;
    logic [ADDR_WIDTH-1:0] ARADDR;
    logic [2:0]            ARPROT;
    logic                  RVALID;
    logic                  RREADY;
    logic [DATA_WIDTH-1:0] RDATA;
    logic [1:0]            RRESP;

    modport master (
        output ARVALID, ARADDR, ARPROT, RREADY,
        input  ARREADY, RVALID, RDATA, RRESP
    );

    modport slave (
        input  ARVALID, ARADDR, ARPROT, RREADY,
        output ARREADY, RVALID, RDATA, RRESP
    );
endinterface

// File: rtl/axi_lite_read_slave.sv
// AXI4-Lite read responder: one fixed-latency local read per AR, OKAY/SLVERR on R.
// Optional one-entry AR skid buffer during RESP is enabled by AXIL_RD_SKID_EN.
module axi_lite_read_slave #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int NUM_REGS   = 16,
    parameter int RD_LATENCY = 2
) (
    input  logic                        ACLK,
    input  logic                        ARESETn,
    axi_lite_read_slave_if.slave        axil,
    output logic                        rd_req,
    output logic [$clog2(NUM_REGS)-1:0] rd_addr,
    output logic [2:0]                  rd_prot,
    input  logic [DATA_WIDTH-1:0]       rd_data
);
    localparam int IDX_W = $clog2(NUM_REGS);
    localparam int CNT_W = (RD_LATENCY > 1) ? $clog2(RD_LATENCY) : 1;
    localparam logic [ADDR_WIDTH-1:0] ADDR_LIMIT = ADDR_WIDTH'(NUM_REGS * 4);

    typedef enum logic [1:0] {IDLE, REQ, WAIT, RESP} state_t;

    state_t                state, state_next;
    logic [CNT_W-1:0]      cnt;
    logic                  arready_q, arready_next;
    logic [DATA_WIDTH-1:0] rdata_q;
    logic [1:0]            rresp_q;
    logic                  ar_hs, r_hs, start, sel_ok;
    logic [ADDR_WIDTH-1:0] sel_addr;
    logic [2:0]            sel_prot;
`ifdef AXIL_RD_SKID_EN
    logic                  buf_valid, buf_valid_next, buf_load;
    logic [ADDR_WIDTH-1:0] buf_addr;
    logic [2:0]            buf_prot;
`endif

    assign axil.ARREADY = arready_q;
    assign axil.RVALID  = (state == RESP);
    assign axil.RDATA   = rdata_q;
    assign axil.RRESP   = rresp_q;
    assign rd_req       = (state == REQ);
    assign ar_hs        = axil.ARVALID && arready_q;
    assign r_hs         = (state == RESP) && axil.RREADY;

    // ARREADY is registered from the next state so it never follows ARVALID
    // and stays low during reset until the first edge after release.
    always_comb begin
        state_next   = state;
        start        = 1'b0;
        sel_addr     = axil.ARADDR;
        sel_prot     = axil.ARPROT;
`ifdef AXIL_RD_SKID_EN
        buf_load       = 1'b0;
        buf_valid_next = buf_valid;
`endif
        case (state)
            IDLE: if (ar_hs) start = 1'b1;
            REQ:  state_next = WAIT;
            WAIT: if (cnt == '0) state_next = RESP;
            RESP: begin
`ifdef AXIL_RD_SKID_EN
                if (r_hs) begin
                    if (buf_valid) begin
                        start          = 1'b1;
                        sel_addr       = buf_addr;
                        sel_prot       = buf_prot;
                        buf_valid_next = 1'b0;
                    end else if (ar_hs) begin
                        start = 1'b1;
                    end else begin
                        state_next = IDLE;
                    end
                end else if (ar_hs) begin
                    buf_load       = 1'b1;
                    buf_valid_next = 1'b1;
                end
`else
                if (r_hs) state_next = IDLE;
`endif
            end
            default: state_next = IDLE;
        endcase

        sel_ok = (sel_addr[1:0] == 2'b00) && (sel_addr < ADDR_LIMIT);
        if (start) state_next = sel_ok ? REQ : RESP;

`ifdef AXIL_RD_SKID_EN
        arready_next = (state_next == IDLE) || ((state_next == RESP) && !buf_valid_next);
`else
        arready_next = (state_next == IDLE);
`endif
    end

    always_ff @(posedge ACLK or posedge ARESETn) begin
        if (ARESETn) begin
            state     <= IDLE;
            arready_q <= 1'b0;
        end else begin
            state     <= state_next;
            arready_q <= arready_next;
        end
    end

    // Decode errors skip the local port and answer with zero data straight away.
    always_ff @(posedge ACLK or posedge ARESETn) begin
        if (ARESETn) begin
            cnt     <= '0;
            rdata_q <= '0;
            rresp_q <= 2'b00;
            rd_addr <= '0;
            rd_prot <= 3'b000;
        end else begin
            if (start && sel_ok) begin
                rd_addr <= sel_addr[IDX_W+1:2];
                rd_prot <= sel_prot;
            end
            if (start && !sel_ok) begin
                rdata_q <= '0;
                rresp_q <= 2'b10;
            end
            if (state == REQ) begin
                cnt <= CNT_W'(RD_LATENCY - 1);
            end else if ((state == WAIT) && (cnt != '0)) begin
                cnt <= cnt - CNT_W'(1);
            end
            if ((state == WAIT) && (cnt == '0)) begin
                rdata_q <= rd_data;
                rresp_q <= 2'b00;
            end
        end
    end

`ifdef AXIL_RD_SKID_EN
    always_ff @(posedge ACLK or posedge ARESETn) begin
        if (ARESETn) begin
            buf_valid <= 1'b0;
            buf_addr  <= '0;
            buf_prot  <= 3'b000;
        end else begin
            buf_valid <= buf_valid_next;
            if (buf_load) begin
                buf_addr <= axil.ARADDR;
                buf_prot <= axil.ARPROT;
            end
        end
    end
`endif
endmodule

// File: tb/tb_axi_lite_read_slave.sv
// Directed self-checking bench for axi_lite_read_slave with a fixed-latency
// register-bank model on the local port (skid steps run when AXIL_RD_SKID_EN is set).
module tb_axi_lite_read_slave;
    localparam int RD_LATENCY = 2;

`ifdef AXIL_RD_SKID_EN
    localparam logic RESP_ARREADY = 1'b1;
`else
    localparam logic RESP_ARREADY = 1'b0;
`endif

    logic        ACLK    = 1'b0;
    logic        ARESETn = 1'b1;
    logic        rd_req;
    logic [3:0]  rd_addr;
    logic [2:0]  rd_prot;
    logic [31:0] rd_data;
    int          compared   = 0;
    int          mismatched = 0;

    logic [31:0]           mem [16];
    logic [RD_LATENCY-1:0] vld_pipe = '0;
    logic [3:0]            adr_pipe [RD_LATENCY];

    axi_lite_read_slave_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) axil ();

    axi_lite_read_slave #(
        .ADDR_WIDTH(32),
        .DATA_WIDTH(32),
        .NUM_REGS  (16),
        .RD_LATENCY(RD_LATENCY)
    ) dut (
        .ACLK   (ACLK),
        .ARESETn(ARESETn),
        .axil   (axil),
        .rd_req (rd_req),
        .rd_addr(rd_addr),
        .rd_prot(rd_prot),
        .rd_data(rd_data)
    );

    always #5 ACLK = ~ACLK;

    // The register model is deliberately not reset, so a read interrupted by
    // reset still returns its data later and must be ignored by the DUT.
    always @(posedge ACLK) begin
        for (int i = RD_LATENCY - 1; i > 0; i--) begin
            vld_pipe[i] <= vld_pipe[i-1];
            adr_pipe[i] <= adr_pipe[i-1];
        end
        vld_pipe[0] <= rd_req;
        adr_pipe[0] <= rd_addr;
    end

    assign rd_data = vld_pipe[RD_LATENCY-1] ? mem[adr_pipe[RD_LATENCY-1]] : 32'hBAD0_BAD0;

    task automatic step(input int n);
        repeat (n) @(negedge ACLK);
    endtask

    task automatic applyStimulus(input logic arvalid, input logic [31:0] araddr,
                                 input logic [2:0] arprot, input logic rready);
        axil.ARVALID = arvalid;
        axil.ARADDR  = araddr;
        axil.ARPROT  = arprot;
        axil.RREADY  = rready;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        compared++;
        assert (observed === expected) else begin
            mismatched++;
            $error("[TB] FAIL %s: observed 0x%08h expected 0x%08h", tag, observed, expected);
        end
    endtask

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: run exceeded its time budget");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        for (int i = 0; i < 16; i++) mem[i] = {16'hA000, 16'(i)};
        mem[2]  = 32'hDEAD_BEEF;
        mem[3]  = 32'hCAFE_F00D;
        mem[15] = 32'h1234_5678;

        // Reset held: everything quiet.
        applyStimulus(1'b0, 32'h0, 3'b000, 1'b0);
        ARESETn = 1'b1;
        step(2);
        checkOutput("rst_arready", 32'(axil.ARREADY), 32'h0);
        checkOutput("rst_rvalid",  32'(axil.RVALID),  32'h0);
        checkOutput("rst_rdata",   axil.RDATA,        32'h0);
        checkOutput("rst_rresp",   32'(axil.RRESP),   32'h0);
        checkOutput("rst_rd_req",  32'(rd_req),       32'h0);
        checkOutput("rst_rd_addr", 32'(rd_addr),      32'h0);
        checkOutput("rst_rd_prot", 32'(rd_prot),      32'h0);
        ARESETn = 1'b0;
        #1;
        checkOutput("rel_arready_before_edge", 32'(axil.ARREADY), 32'h0);
        step(1);
        checkOutput("rel_arready_after_edge", 32'(axil.ARREADY), 32'h1);

        // OKAY read of word 2.
        applyStimulus(1'b1, 32'h8, 3'b010, 1'b1);
        step(1);
        checkOutput("ok_rd_req",   32'(rd_req),       32'h1);
        checkOutput("ok_rd_addr",  32'(rd_addr),      32'h2);
        checkOutput("ok_rd_prot",  32'(rd_prot),      32'h2);
        checkOutput("ok_arready",  32'(axil.ARREADY), 32'h0);
        checkOutput("ok_rvalid_1", 32'(axil.RVALID),  32'h0);
        applyStimulus(1'b0, 32'h0, 3'b000, 1'b1);
        step(1);
        checkOutput("ok_rd_req_pulse", 32'(rd_req), 32'h0);
        step(1);
        checkOutput("ok_rvalid_3", 32'(axil.RVALID), 32'h0);
        step(1);
        checkOutput("ok_rvalid_4", 32'(axil.RVALID), 32'h1);
        checkOutput("ok_rdata",    axil.RDATA,       32'hDEAD_BEEF);
        checkOutput("ok_rresp",    32'(axil.RRESP),  32'h0);
        step(1);
        checkOutput("ok_rvalid_done",  32'(axil.RVALID),  32'h0);
        checkOutput("ok_arready_done", 32'(axil.ARREADY), 32'h1);

        // Decode errors: first address past the bank, then a misaligned one.
        applyStimulus(1'b1, 32'h40, 3'b000, 1'b1);
        step(1);
        checkOutput("err40_rvalid", 32'(axil.RVALID), 32'h1);
        checkOutput("err40_rresp",  32'(axil.RRESP),  32'h2);
        checkOutput("err40_rdata",  axil.RDATA,       32'h0);
        checkOutput("err40_rd_req", 32'(rd_req),      32'h0);
        applyStimulus(1'b0, 32'h0, 3'b000, 1'b1);
        step(1);
        checkOutput("err40_rvalid_done", 32'(axil.RVALID),  32'h0);
        checkOutput("err40_arready",     32'(axil.ARREADY), 32'h1);
        applyStimulus(1'b1, 32'h6, 3'b000, 1'b1);
        step(1);
        checkOutput("err06_rvalid",  32'(axil.RVALID), 32'h1);
        checkOutput("err06_rresp",   32'(axil.RRESP),  32'h2);
        checkOutput("err06_rdata",   axil.RDATA,       32'h0);
        checkOutput("err06_rd_req",  32'(rd_req),      32'h0);
        checkOutput("err06_rd_addr", 32'(rd_addr),     32'h2);
        applyStimulus(1'b0, 32'h0, 3'b000, 1'b1);
        step(1);
        checkOutput("err06_arready", 32'(axil.ARREADY), 32'h1);

        // Last valid word with R backpressure.
        applyStimulus(1'b1, 32'h3C, 3'b101, 1'b0);
        step(1);
        checkOutput("bp_rd_req",  32'(rd_req),  32'h1);
        checkOutput("bp_rd_addr", 32'(rd_addr), 32'hF);
        checkOutput("bp_rd_prot", 32'(rd_prot), 32'h5);
        applyStimulus(1'b0, 32'h0, 3'b000, 1'b0);
        step(2);
        checkOutput("bp_rvalid_early", 32'(axil.RVALID), 32'h0);
        step(1);
        checkOutput("bp_rvalid", 32'(axil.RVALID), 32'h1);
        checkOutput("bp_rdata",  axil.RDATA,       32'h1234_5678);
        for (int i = 0; i < 5; i++) begin
            step(1);
            checkOutput("bp_hold_rvalid",  32'(axil.RVALID),  32'h1);
            checkOutput("bp_hold_rdata",   axil.RDATA,        32'h1234_5678);
            checkOutput("bp_hold_rresp",   32'(axil.RRESP),   32'h0);
            checkOutput("bp_hold_arready", 32'(axil.ARREADY), 32'(RESP_ARREADY));
        end
        applyStimulus(1'b0, 32'h0, 3'b000, 1'b1);
        step(1);
        checkOutput("bp_rvalid_done",  32'(axil.RVALID),  32'h0);
        checkOutput("bp_arready_done", 32'(axil.ARREADY), 32'h1);

        // Asynchronous reset while the local read is still in flight.
        applyStimulus(1'b1, 32'hC, 3'b011, 1'b1);
        step(1);
        checkOutput("mid_rd_req", 32'(rd_req), 32'h1);
        applyStimulus(1'b0, 32'h0, 3'b000, 1'b1);
        step(1);
        ARESETn = 1'b1;
        #1;
        checkOutput("mid_arready", 32'(axil.ARREADY), 32'h0);
        checkOutput("mid_rvalid",  32'(axil.RVALID),  32'h0);
        checkOutput("mid_rdata",   axil.RDATA,        32'h0);
        checkOutput("mid_rresp",   32'(axil.RRESP),   32'h0);
        checkOutput("mid_rd_req",  32'(rd_req),       32'h0);
        checkOutput("mid_rd_addr", 32'(rd_addr),      32'h0);
        checkOutput("mid_rd_prot", 32'(rd_prot),      32'h0);
        #1;
        ARESETn = 1'b0;
        step(1);
        checkOutput("mid_rel_arready", 32'(axil.ARREADY), 32'h1);
        checkOutput("mid_rel_rvalid",  32'(axil.RVALID),  32'h0);
        checkOutput("mid_rel_rdata",   axil.RDATA,        32'h0);
        step(1);
        checkOutput("mid_stale_rvalid", 32'(axil.RVALID), 32'h0);
        checkOutput("mid_stale_rdata",  axil.RDATA,       32'h0);

`ifdef AXIL_RD_SKID_EN
        // Second AR buffered during RESP, dispatched straight after the R handshake.
        applyStimulus(1'b1, 32'h8, 3'b000, 1'b0);
        step(1);
        checkOutput("skid_rd_req_a", 32'(rd_req), 32'h1);
        applyStimulus(1'b0, 32'h0, 3'b000, 1'b0);
        step(3);
        checkOutput("skid_rvalid_a",  32'(axil.RVALID),  32'h1);
        checkOutput("skid_rdata_a",   axil.RDATA,        32'hDEAD_BEEF);
        checkOutput("skid_arready_a", 32'(axil.ARREADY), 32'h1);
        applyStimulus(1'b1, 32'hC, 3'b001, 1'b0);
        step(1);
        checkOutput("skid_full_rvalid",  32'(axil.RVALID),  32'h1);
        checkOutput("skid_full_rdata",   axil.RDATA,        32'hDEAD_BEEF);
        checkOutput("skid_full_arready", 32'(axil.ARREADY), 32'h0);
        checkOutput("skid_full_rd_req",  32'(rd_req),       32'h0);
        applyStimulus(1'b0, 32'h0, 3'b000, 1'b1);
        step(1);
        checkOutput("skid_rd_req_b",  32'(rd_req),      32'h1);
        checkOutput("skid_rd_addr_b", 32'(rd_addr),     32'h3);
        checkOutput("skid_rd_prot_b", 32'(rd_prot),     32'h1);
        checkOutput("skid_rvalid_b0", 32'(axil.RVALID), 32'h0);
        applyStimulus(1'b0, 32'h0, 3'b000, 1'b0);
        step(3);
        checkOutput("skid_rvalid_b",  32'(axil.RVALID),  32'h1);
        checkOutput("skid_rdata_b",   axil.RDATA,        32'hCAFE_F00D);
        checkOutput("skid_arready_b", 32'(axil.ARREADY), 32'h1);

        // AR and R handshakes on the same edge.
        applyStimulus(1'b1, 32'h3C, 3'b000, 1'b1);
        step(1);
        checkOutput("sim_rd_req",  32'(rd_req),       32'h1);
        checkOutput("sim_rd_addr", 32'(rd_addr),      32'hF);
        checkOutput("sim_rvalid",  32'(axil.RVALID),  32'h0);
        checkOutput("sim_arready", 32'(axil.ARREADY), 32'h0);
        applyStimulus(1'b0, 32'h0, 3'b000, 1'b1);
        step(3);
        checkOutput("sim_rvalid_c", 32'(axil.RVALID), 32'h1);
        checkOutput("sim_rdata_c",  axil.RDATA,       32'h1234_5678);
        checkOutput("sim_rresp_c",  32'(axil.RRESP),  32'h0);
        step(1);
        checkOutput("sim_rvalid_done",  32'(axil.RVALID),  32'h0);
        checkOutput("sim_arready_done", 32'(axil.ARREADY), 32'h1);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule

// File: doc/axi_lite_read_slave.md
# axi_lite_read_slave

AXI4-Lite read-channel responder: accepts AR handshakes, performs one fixed-latency read on a local register-bank port per address, and returns the data on the R channel with OKAY or SLVERR. It is the read-side counterpart of the write-address master/slave path and sits between the AXI4-Lite interconnect and the peripheral register file. Only single outstanding transactions are supported, with one optional buffered address.

## Interface
- ADDR_WIDTH, 32, AR address width
- DATA_WIDTH, 32, RDATA / local read-data width
- NUM_REGS, 16, number of 32-bit words decoded from byte address 0
- RD_LATENCY, 2, cycles from rd_req to valid rd_data; must be ≥1

- ACLK  input  1  clock; all logic on rising edge
- ARESETn  input  1  reset; asynchronous, active-high
- ARVALID  input  1  read address valid
- ARREADY  output  1  read address ready
- ARADDR  input  ADDR_WIDTH  byte address
- ARPROT  input  3  protection attributes
- RVALID  output  1  read data valid
- RREADY  input  1  read data ready
- RDATA  output  DATA_WIDTH  read data
- RRESP  output  2  2'b00 OKAY, 2'b10 SLVERR
- rd_req  output  1  one-cycle local read strobe
- rd_addr  output  $clog2(NUM_REGS)  word index (ARADDR[.. :2])
- rd_prot  output  3  ARPROT of the current access
- rd_data  input  DATA_WIDTH  local read data, valid RD_LATENCY cycles after rd_req

## Operation
- FSM states: IDLE, REQ, WAIT, RESP.
- IDLE: ARREADY=1. On ARVALID&&ARREADY, latch ARADDR/ARPROT and decode.
  - OKAY: ARADDR[1:0]==0 and ARADDR < NUM_REGS*4 → REQ.
  - Otherwise, SLVERR → RESP directly, with RDATA=0 and RRESP=2'b10. No rd_req.
- REQ: rd_req=1 for exactly one cycle; rd_addr and rd_prot are driven. Load the counter with RD_LATENCY-1 → WAIT.
- WAIT: decrement the counter. When the counter is 0, register rd_data into RDATA, set RRESP=2'b00 → RESP.
- RESP: RVALID=1. RDATA and RRESP are held stable until RREADY. On RVALID&&RREADY:
  - go to IDLE, or
  - with a buffered address (see Configuration), go to REQ or RESP according to that address's decode.
- ARREADY is low in REQ/WAIT always. In RESP it is low unless AXIL_RD_SKID_EN is defined.
- rd_addr and rd_prot hold their last value outside REQ.
- Reset (asynchronous, any state, including mid-WAIT or in RESP with RVALID high):
  - ARREADY=0, RVALID=0, RDATA=0, RRESP=0, rd_req=0, rd_addr=0, rd_prot=0.
  - FSM goes to IDLE; the buffer is cleared; an in-flight local read is discarded.
  - ARREADY rises on the first ACLK edge after ARESETn falls.

## Timing
- AR handshake on edge h (OKAY path):
  - rd_req high in cycle h+1.
  - RDATA is captured at the edge ending cycle h+1+RD_LATENCY.
  - RVALID is high from cycle h+RD_LATENCY+2.
- SLVERR path: RVALID is high from cycle h+1.
- R handshake on edge r, no buffered address: ARREADY high in cycle r+1. Back-to-back OKAY throughput is one transfer per RD_LATENCY+3 cycles.
- RVALID never depends combinationally on RREADY. ARREADY never depends combinationally on ARVALID.
- RVALID is never deasserted before the handshake.

## Configuration
- AXIL_RD_SKID_EN defined:
  - Adds a one-entry address/prot buffer. ARREADY is high in RESP while the buffer is empty.
  - An AR handshake during RESP fills the buffer.
  - On the R handshake, the FSM proceeds directly to REQ (or RESP for SLVERR) from the buffer and the buffer empties.
  - ARREADY is high again in the cycle after the buffer empties, when the state is IDLE or RESP.
  - A simultaneous AR and R handshake in RESP is legal: the new address is buffered and consumed on the same edge, and the FSM enters REQ next.
- Undefined: no buffer; ARREADY high only in IDLE.

## Test plan
- Reset/IDLE read:
  - Stimulus: reset, then ARADDR=0x8, ARVALID for 1 cycle, rd_data=0xDEADBEEF, RREADY=1, RD_LATENCY=2.
  - Response: rd_req pulse with rd_addr=2; RVALID 4 cycles after handshake; RDATA=0xDEADBEEF, RRESP=00.
- Decode error:
  - Stimulus: ARADDR=0x40 (NUM_REGS=16), then ARADDR=0x6.
  - Response: each gives RVALID the next cycle, RRESP=10, RDATA=0, no rd_req.
- Backpressure:
  - Stimulus: RREADY=0 for 5 cycles after RVALID.
  - Response: RVALID, RDATA and RRESP are stable throughout; ARREADY stays low (macro off); IDLE follows the handshake.
- Reset mid-operation:
  - Stimulus: assert ARESETn during WAIT, with no clock edge.
  - Response: all outputs go to 0 immediately; after release, ARREADY=1 on the next edge; the stale rd_data never appears on RDATA.
- Skid (AXIL_RD_SKID_EN):
  - Stimulus: second ARADDR=0xC presented while RVALID is held with RREADY=0.
  - Response: AR is accepted in RESP; after the R handshake, rd_req occurs the next cycle with rd_addr=3 and no IDLE cycle.
- Skid, simultaneous handshakes:
  - Stimulus: AR and R handshakes on the same edge.
  - Response: both are accepted; the second read completes with the correct data.
